// File: rtl/mode_mux_pkg.sv
// Shared definitions for the registered mode multiplexer.
//   ST_RUN / ST_GUARD : FSM state encodings.
//   GUARD_W           : width of the dead-time counter.
//   ch_w()            : channel-select width for a given channel count, never below 1.
package mode_mux_pkg;

  localparam logic ST_RUN   = 1'b0;
  localparam logic ST_GUARD = 1'b1;

  localparam int unsigned GUARD_W = 8;

  function automatic int unsigned ch_w(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mode_guard_ctr.sv
// Loadable down counter that times the dead-time interval of a mode switch.
// It saturates at zero, so it idles at zero while no switch is in progress.
//   clk      : system clock, rising edge
//   rst_n    : asynchronous active-low reset, clears the count
//   load     : load load_val on the next edge; this takes priority over the decrement
//   load_val : value to load
//   zero     : count is zero
module mode_guard_ctr
  import mode_mux_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic [GUARD_W-1:0] load_val,
  output logic               zero
);

  logic [GUARD_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - GUARD_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/mode_mux_seq.sv
// Registered N-channel mode multiplexer with a handshaked, guarded mode switch.
// Out of reset it selects channel RST_MODE. A mode change is requested with mode_req and
// mode_req_vld, and is accepted only in RUN. While the switch is in progress, dout_vld stays
// low for GUARD_CYCLES cycles, so downstream logic never sees a half-switched output.
//   clk, rst_n   : clock, asynchronous active-low reset
//   din          : flattened channels, channel k = din[k*WIDTH +: WIDTH]
//   mode_req     : requested channel
//   mode_req_vld : request valid
//   mode_req_rdy : request can be accepted (RUN only)
//   mode_cur     : active channel
//   dout         : registered output data
//   dout_vld     : dout is valid for mode_cur
//   mode_ack     : one-cycle pulse, the requested mode is active
//   mode_err     : one-cycle pulse, the request was out of range
// Build option MODE_MUX_BLANK_EN: when it is defined, dout is forced to zero for the whole
// guard interval. When it is undefined, dout holds the old channel's last value.
module mode_mux_seq
  import mode_mux_pkg::*;
#(
  parameter  int unsigned NCH          = 4,
  parameter  int unsigned WIDTH        = 4,
  parameter  int unsigned GUARD_CYCLES = 4,
  parameter  int unsigned RST_MODE     = 0,
  localparam int unsigned CH_W         = ch_w(NCH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NCH*WIDTH-1:0] din,
  input  logic [CH_W-1:0]      mode_req,
  input  logic                 mode_req_vld,
  output logic                 mode_req_rdy,
  output logic [CH_W-1:0]      mode_cur,
  output logic [WIDTH-1:0]     dout,
  output logic                 dout_vld,
  output logic                 mode_ack,
  output logic                 mode_err
);

  logic [WIDTH-1:0] ch [NCH];

  for (genvar k = 0; k < NCH; k++) begin : g_ch
    assign ch[k] = din[k*WIDTH +: WIDTH];
  end

  logic             state_q, state_d;
  logic [CH_W-1:0]  mode_cur_q, mode_cur_d;
  logic [CH_W-1:0]  pend_q, pend_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             vld_q, vld_d;
  logic             ack_q, ack_d;
  logic             err_q, err_d;
  logic             ctr_load;
  logic             guard_zero;
  logic             req_in_range;

  // Codes from NCH up to 2^CH_W-1 exist only when NCH is not a power of two.
  assign req_in_range = (32'(mode_req) < NCH);

  always_comb begin
    state_d    = state_q;
    mode_cur_d = mode_cur_q;
    pend_d     = pend_q;
    dout_d     = dout_q;
    vld_d      = vld_q;
    ack_d      = 1'b0;
    err_d      = 1'b0;
    ctr_load   = 1'b0;
    case (state_q)
      ST_RUN: begin
        dout_d = ch[mode_cur_q];
        vld_d  = 1'b1;
        if (mode_req_vld) begin
          if (!req_in_range) begin
            err_d = 1'b1;
          end else if (mode_req == mode_cur_q) begin
            ack_d = 1'b1;
          end else begin
            pend_d   = mode_req;
            ctr_load = 1'b1;
            state_d  = ST_GUARD;
            vld_d    = 1'b0;
`ifdef MODE_MUX_BLANK_EN
            dout_d   = '0;
`endif
          end
        end
      end
      ST_GUARD: begin
        // dout is not reloaded here. It keeps the blanked or stale value until the switch ends.
        if (guard_zero) begin
          state_d    = ST_RUN;
          mode_cur_d = pend_q;
          dout_d     = ch[pend_q];
          vld_d      = 1'b1;
          ack_d      = 1'b1;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_RUN;
      mode_cur_q <= CH_W'(RST_MODE);
      pend_q     <= CH_W'(RST_MODE);
      dout_q     <= '0;
      vld_q      <= 1'b0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      mode_cur_q <= mode_cur_d;
      pend_q     <= pend_d;
      dout_q     <= dout_d;
      vld_q      <= vld_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
    end
  end

  // The counter is loaded with GUARD_CYCLES-1 because the edge on which it reads zero is
  // itself the last guard cycle.
  mode_guard_ctr u_guard_ctr (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (ctr_load),
    .load_val (GUARD_W'(GUARD_CYCLES - 1)),
    .zero     (guard_zero)
  );

  assign mode_req_rdy = (state_q == ST_RUN);
  assign mode_cur     = mode_cur_q;
  assign dout         = dout_q;
  assign dout_vld     = vld_q;
  assign mode_ack     = ack_q;
  assign mode_err     = err_q;

endmodule

// File: tb/tb_mode_mux_seq.sv
// Directed bench for mode_mux_seq.
// The main instance uses NCH=4. A second instance with NCH=3 exercises the out-of-range code.
module tb_mode_mux_seq;

`ifdef MODE_MUX_BLANK_EN
  localparam bit BLANK = 1'b1;
`else
  localparam bit BLANK = 1'b0;
`endif

  localparam logic [3:0] CA = 4'b1010;
  localparam logic [3:0] CB = 4'b1100;
  localparam logic [3:0] CC = 4'b1111;
  localparam logic [3:0] CD = 4'b1001;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] din;
  logic [1:0]  mode_req = '0;
  logic        mode_req_vld = 1'b0;
  logic        mode_req_rdy;
  logic [1:0]  mode_cur;
  logic [3:0]  dout;
  logic        dout_vld, mode_ack, mode_err;

  logic [11:0] din3;
  logic [1:0]  mode_req3 = '0;
  logic        mode_req_vld3 = 1'b0;
  logic        mode_req_rdy3;
  logic [1:0]  mode_cur3;
  logic [3:0]  dout3;
  logic        dout_vld3, mode_ack3, mode_err3;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mode_mux_seq #(.NCH(4), .WIDTH(4), .GUARD_CYCLES(4), .RST_MODE(0)) u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .din          (din),
    .mode_req     (mode_req),
    .mode_req_vld (mode_req_vld),
    .mode_req_rdy (mode_req_rdy),
    .mode_cur     (mode_cur),
    .dout         (dout),
    .dout_vld     (dout_vld),
    .mode_ack     (mode_ack),
    .mode_err     (mode_err)
  );

  mode_mux_seq #(.NCH(3), .WIDTH(4), .GUARD_CYCLES(4), .RST_MODE(0)) u_dut3 (
    .clk          (clk),
    .rst_n        (rst_n),
    .din          (din3),
    .mode_req     (mode_req3),
    .mode_req_vld (mode_req_vld3),
    .mode_req_rdy (mode_req_rdy3),
    .mode_cur     (mode_cur3),
    .dout         (dout3),
    .dout_vld     (dout_vld3),
    .mode_ack     (mode_ack3),
    .mode_err     (mode_err3)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Checks a four-cycle guard window. The accepting edge has already been ticked on entry.
  task automatic guard_window(input string tag, input logic [3:0] old_val, input logic [1:0] cur);
    for (int i = 0; i < 4; i++) begin
      check({tag, "_vld"}, dout_vld, 1'b0);
      check({tag, "_rdy"}, mode_req_rdy, 1'b0);
      check({tag, "_dout"}, dout, BLANK ? 4'b0000 : old_val);
      check({tag, "_cur"}, mode_cur, cur);
      check({tag, "_ack"}, mode_ack, 1'b0);
      tick();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within the time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    din  = {CD, CC, CB, CA};
    din3 = {CC, CB, CA};

    // 1: reset values, then the first edge after release.
    #2;
    check("rst_dout", dout, 4'b0000);
    check("rst_vld", dout_vld, 1'b0);
    check("rst_cur", mode_cur, 2'd0);
    check("rst_rdy", mode_req_rdy, 1'b1);
    check("rst_ack", mode_ack, 1'b0);
    check("rst_err", mode_err, 1'b0);
    tick();
    check("rst_hold_vld", dout_vld, 1'b0);
    rst_n = 1'b1;
    tick();
    check("rel_dout", dout, CA);
    check("rel_vld", dout_vld, 1'b1);
    check("rel_cur", mode_cur, 2'd0);

    // 2: switch to mode 2.
    mode_req = 2'd2; mode_req_vld = 1'b1;
    check("t2_rdy_before", mode_req_rdy, 1'b1);
    tick();
    mode_req_vld = 1'b0;
    guard_window("t2_guard", CA, 2'd0);
    check("t2_exit_dout", dout, CC);
    check("t2_exit_vld", dout_vld, 1'b1);
    check("t2_exit_cur", mode_cur, 2'd2);
    check("t2_exit_ack", mode_ack, 1'b1);
    tick();
    check("t2_ack_once", mode_ack, 1'b0);

    // 3: request the mode that is already active.
    mode_req = 2'd2; mode_req_vld = 1'b1;
    tick();
    mode_req_vld = 1'b0;
    check("t3_ack", mode_ack, 1'b1);
    check("t3_err", mode_err, 1'b0);
    check("t3_vld", dout_vld, 1'b1);
    check("t3_dout", dout, CC);
    check("t3_cur", mode_cur, 2'd2);
    din[11:8] = 4'b0111;
    tick();
    check("t3_ack_once", mode_ack, 1'b0);
    check("t3_latency", dout, 4'b0111);
    check("t3_vld2", dout_vld, 1'b1);
    din[11:8] = CC;
    tick();

    // 4: NCH=3 instance, code 3 is rejected.
    mode_req3 = 2'd3; mode_req_vld3 = 1'b1;
    tick();
    mode_req_vld3 = 1'b0;
    check("t4_err", mode_err3, 1'b1);
    check("t4_ack", mode_ack3, 1'b0);
    check("t4_cur", mode_cur3, 2'd0);
    check("t4_vld", dout_vld3, 1'b1);
    check("t4_dout", dout3, CA);
    tick();
    check("t4_err_once", mode_err3, 1'b0);
    check("t4_rdy", mode_req_rdy3, 1'b1);
    check("t4_vld2", dout_vld3, 1'b1);

    // 5: reset during guard cycle 2 aborts the switch.
    mode_req = 2'd3; mode_req_vld = 1'b1;
    tick();
    mode_req_vld = 1'b0;
    check("t5_g1_vld", dout_vld, 1'b0);
    tick();
    check("t5_g2_rdy", mode_req_rdy, 1'b0);
    rst_n = 1'b0;
    #1;
    check("t5_rst_dout", dout, 4'b0000);
    check("t5_rst_vld", dout_vld, 1'b0);
    check("t5_rst_cur", mode_cur, 2'd0);
    check("t5_rst_rdy", mode_req_rdy, 1'b1);
    tick();
    rst_n = 1'b1;
    tick();
    check("t5_rel_dout", dout, CA);
    check("t5_rel_cur", mode_cur, 2'd0);
    check("t5_rel_vld", dout_vld, 1'b1);
    for (int i = 0; i < 6; i++) begin
      check("t5_no_ack", mode_ack, 1'b0);
      check("t5_cur_stable", mode_cur, 2'd0);
      tick();
    end

    // 6: vld is held and mode_req changes during the guard, so mode 1 completes first, then mode 3.
    mode_req = 2'd1; mode_req_vld = 1'b1;
    tick();
    mode_req = 2'd3;
    guard_window("t6_g1", CA, 2'd0);
    check("t6_ack1", mode_ack, 1'b1);
    check("t6_cur1", mode_cur, 2'd1);
    check("t6_dout1", dout, CB);
    check("t6_rdy1", mode_req_rdy, 1'b1);
    tick();
    mode_req_vld = 1'b0;
    guard_window("t6_g2", CB, 2'd1);
    check("t6_ack3", mode_ack, 1'b1);
    check("t6_err3", mode_err, 1'b0);
    check("t6_cur3", mode_cur, 2'd3);
    check("t6_dout3", dout, CD);
    check("t6_vld3", dout_vld, 1'b1);
    tick();
    check("t6_ack_once", mode_ack, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
